// File: rtl/bc_pkg.sv
// Shared types and constants for the bulls-and-cows game controller and scorer.
// Pure declarations: no latency, no backpressure.
package bc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    ENTRY,
    SCORE,
    WIN,
    LOSE
  } state_t;

  localparam int          DIGITS       = 4;
  localparam int          GUESS_W      = 40;
  localparam int          ANSWER_W     = 16;
  localparam logic [3:0]  NIBBLE_BLANK = 4'hF;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // True when d equals one of the first count nibbles of vec.
  function automatic logic nib_hit(input logic [15:0] vec, input logic [2:0] count,
                                   input logic [3:0] d);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k < int'(count) && vec[k*4 +: 4] == d) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/bc_game_ctrl_if.sv
// Keypad, scorer and display signals of the game controller, bundled as one port.
// Latency and backpressure are set by the controller; all strobes are one-cycle pulses.
interface bc_game_ctrl_if;
  import bc_pkg::*;

  logic                start;
  logic                digit_valid;
  logic [3:0]          digit;
  logic                backspace;
  logic                submit;
  logic [3:0]          strike_in;
  logic [3:0]          ball_in;
  logic [GUESS_W-1:0]  guess;
  logic [ANSWER_W-1:0] answer;
  logic [2:0]          entry_count;
  logic [3:0]          try_count;
  logic [3:0]          last_strike;
  logic [3:0]          last_ball;
  logic                result_valid;
  logic                busy;
  logic                win;
  logic                lose;

  modport master (
    output start, digit_valid, digit, backspace, submit, strike_in, ball_in,
    input  guess, answer, entry_count, try_count, last_strike, last_ball,
           result_valid, busy, win, lose
  );

  modport slave (
    input  start, digit_valid, digit, backspace, submit, strike_in, ball_in,
    output guess, answer, entry_count, try_count, last_strike, last_ball,
           result_valid, busy, win, lose
  );
endinterface

// File: rtl/bc_digit_lfsr.sv
// Free-running 16-bit Fibonacci LFSR offering a candidate answer digit every cycle.
// Latency: candidate is combinational from the register; no backpressure, shifts every cycle.
module bc_digit_lfsr
  import bc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] candidate,
  output logic       cand_ok
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= {lfsr_q[14:0], fb};
  end

  assign candidate = lfsr_q[3:0];
  assign cand_ok   = (candidate <= 4'd9);

endmodule

// File: rtl/bc_scorer.sv
// Combinational bulls-and-cows scorer: strikes are position matches, balls are digit matches elsewhere.
// Latency: zero cycles; no backpressure.
module bc_scorer
  import bc_pkg::*;
(
  input  logic [GUESS_W-1:0]  guess,
  input  logic [ANSWER_W-1:0] answer,
  output logic [3:0]          strike,
  output logic [3:0]          ball
);

  // Blank nibbles (4'hF) never equal a legal answer digit, so scanning every
  // guess nibble is harmless and keeps the blank upper nibbles from matching.
  always_comb begin
    strike = 4'd0;
    ball   = 4'd0;
    for (int k = 0; k < GUESS_W / 4; k++) begin
      for (int j = 0; j < DIGITS; j++) begin
        if (guess[k*4 +: 4] == answer[j*4 +: 4]) begin
          if (k == j) strike = strike + 4'd1;
          else        ball   = ball + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bc_game_ctrl.sv
// Bulls-and-cows game sequencer: draws a secret, gathers a guess, scores it, tracks tries to win/lose.
// Latency: submit at N -> SCORE at N+1 -> result_valid/win/lose at N+2; no backpressure, inputs ignored when illegal.
module bc_game_ctrl
  import bc_pkg::*;
#(
  parameter int          MAX_TRIES = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  bc_game_ctrl_if.slave bus
);

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);
  localparam logic [2:0] FULL  = 3'(DIGITS);

  state_t        state_q, state_d;
  logic [15:0]   answer_q, answer_d;
  logic [15:0]   guess_q, guess_d;
  logic [2:0]    gen_idx_q, gen_idx_d;
  logic [2:0]    entry_q, entry_d;
  logic [3:0]    try_q, try_d;
  logic [3:0]    strike_q, strike_d;
  logic [3:0]    ball_q, ball_d;
  logic          rvalid_q, rvalid_d;

  logic [3:0]    candidate;
  logic          cand_ok;
  logic [1:0]    bs_idx;

  bc_digit_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .candidate (candidate),
    .cand_ok   (cand_ok)
  );

  assign bs_idx = entry_q[1:0] - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      answer_q  <= '0;
      guess_q   <= {DIGITS{NIBBLE_BLANK}};
      gen_idx_q <= '0;
      entry_q   <= '0;
      try_q     <= '0;
      strike_q  <= '0;
      ball_q    <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      answer_q  <= answer_d;
      guess_q   <= guess_d;
      gen_idx_q <= gen_idx_d;
      entry_q   <= entry_d;
      try_q     <= try_d;
      strike_q  <= strike_d;
      ball_q    <= ball_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    answer_d  = answer_q;
    guess_d   = guess_q;
    gen_idx_d = gen_idx_q;
    entry_d   = entry_q;
    try_d     = try_q;
    strike_d  = strike_q;
    ball_d    = ball_q;
    rvalid_d  = 1'b0;

    if (bus.start) begin
      state_d   = GEN;
      answer_d  = '0;
      guess_d   = {DIGITS{NIBBLE_BLANK}};
      gen_idx_d = '0;
      entry_d   = '0;
      try_d     = '0;
      strike_d  = '0;
      ball_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        GEN: begin
          if (cand_ok && !nib_hit(answer_q, gen_idx_q, candidate)) begin
            answer_d[{gen_idx_q[1:0], 2'b00} +: 4] = candidate;
            gen_idx_d = gen_idx_q + 3'd1;
            if (gen_idx_q == FULL - 3'd1) state_d = ENTRY;
          end
        end
        ENTRY: begin
          if (bus.backspace) begin
            if (entry_q != 3'd0) begin
              entry_d = entry_q - 3'd1;
              guess_d[{bs_idx, 2'b00} +: 4] = NIBBLE_BLANK;
            end
          end else if (bus.submit) begin
            if (entry_q == FULL) state_d = SCORE;
          end else if (bus.digit_valid && bus.digit <= 4'd9 && entry_q < FULL &&
                       !nib_hit(guess_q, entry_q, bus.digit)) begin
            guess_d[{entry_q[1:0], 2'b00} +: 4] = bus.digit;
            entry_d = entry_q + 3'd1;
          end
        end
        SCORE: begin
          strike_d = bus.strike_in;
          ball_d   = bus.ball_in;
          try_d    = try_q + 4'd1;
          rvalid_d = 1'b1;
          if (bus.strike_in == 4'd4) begin
            state_d = WIN;
          end else if (try_q + 4'd1 == MAX_T) begin
            state_d = LOSE;
          end else begin
            state_d = ENTRY;
            guess_d = {DIGITS{NIBBLE_BLANK}};
            entry_d = '0;
          end
        end
        WIN, LOSE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.guess        = {{(GUESS_W - 16) / 4{NIBBLE_BLANK}}, guess_q};
  assign bus.answer       = answer_q;
  assign bus.entry_count  = entry_q;
  assign bus.try_count    = try_q;
  assign bus.last_strike  = strike_q;
  assign bus.last_ball    = ball_q;
  assign bus.result_valid = rvalid_q;
  assign bus.busy         = (state_q == GEN) || (state_q == SCORE);
  assign bus.win          = (state_q == WIN);
  assign bus.lose         = (state_q == LOSE);

endmodule

// File: doc/bc_game_ctrl.md
Name: bc_game_ctrl

Overview:
Sequential game controller for the bulls-and-cows datapath. It draws a 4-digit secret answer with no repeated digits, collects the player's guess digit by digit, and drives the combinational scorer's guess/answer inputs. It consumes the scorer's strike/ball results, counts attempts, and declares win or lose. The block sits between the keypad/debounce front end and the LCD/display stage.

Parameters:
MAX_TRIES, 9, number of scored guesses before LOSE (1..15)
LFSR_SEED, 16'hACE1, reset value of the answer LFSR (must be nonzero)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin a new game (aborts any game in progress)
digit_valid  in  1  one-cycle pulse; digit carries a keypad value
digit  in  4  keypad value; only 0..9 are legal
backspace  in  1  one-cycle pulse; remove the last entered digit
submit  in  1  one-cycle pulse; score the current guess
strike_in  in  4  strike count from the scorer (combinational on guess/answer)
ball_in  in  4  ball count from the scorer
guess  out  40  to scorer; nibble k = k-th entered digit (k=0..3); unused nibbles = 4'hF
answer  out  16  to scorer; nibble k = k-th secret digit
entry_count  out  3  digits entered so far (0..4)
try_count  out  4  guesses scored this game
last_strike  out  4  registered strike of the last scored guess
last_ball  out  4  registered ball of the last scored guess
result_valid  out  1  one-cycle pulse; last_strike/last_ball were just updated
busy  out  1  high in GEN and SCORE
win  out  1  high while in WIN
lose  out  1  high while in LOSE

Behaviour:
- Reset (async): state IDLE; guess=40'hFF_FFFF_FFFF; answer=0; entry_count, try_count, last_strike, last_ball = 0; result_valid, win, lose = 0; LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle in every state; it never reaches zero.
- Nibble 4'hF never matches a legal answer digit, so blank and upper guess nibbles (bits 39:16) never create false balls. Bits 39:16 are always 4'hF.
- States: IDLE, GEN, ENTRY, SCORE, WIN, LOSE.
- start in any state: the next state is GEN. Same cycle: answer, gen_idx, entry_count, try_count, win, lose, last_* cleared; guess set to all-F. start has top priority over every other input.
- IDLE: waits for start.
- GEN: each cycle, candidate = lfsr[3:0]. Accept when candidate<10 and it differs from the answer nibbles 0..gen_idx-1. An accepted candidate is written to nibble gen_idx and gen_idx increments. After the 4th accept, go to ENTRY. At most one accept per cycle.
- ENTRY, input priority: backspace > submit > digit_valid.
  - backspace with entry_count>0: decrement, set that nibble to 4'hF. Ignored when entry_count=0.
  - submit with entry_count=4: go to SCORE. Ignored otherwise, with no state change.
  - digit_valid: accept only if digit<=9, entry_count<4 and digit not equal to any entered nibble. Write nibble entry_count, increment. Otherwise ignore silently.
- SCORE (exactly 1 cycle; guess is stable, so scorer output is settled):
  - Register last_strike=strike_in, last_ball=ball_in; try_count+1; result_valid=1 in the following cycle only.
  - If strike_in==4: go to WIN.
  - Else if try_count+1==MAX_TRIES: go to LOSE.
  - Else go to ENTRY with guess reset to all-F and entry_count=0.
  - Keypad inputs are ignored in SCORE.
- WIN/LOSE: win or lose held high. guess, answer and last_* are held for display. Only start or rst leaves these states.
- Latency: submit accepted at cycle N → SCORE at N+1 → result_valid, and win/lose if applicable, at N+2.
- try_count saturates by construction, since LOSE is reached at MAX_TRIES.

Decomposition:
- Package bc_pkg: state enum (IDLE, GEN, ENTRY, SCORE, WIN, LOSE), DIGITS=4, GUESS_W=40, ANSWER_W=16, NIBBLE_BLANK=4'hF, LFSR tap constant.
- One sub-module, bc_digit_lfsr: holds the LFSR and outputs candidate[3:0] plus cand_ok (candidate<10). The duplicate check stays in bc_game_ctrl.
- The bench instantiates bc_game_ctrl together with the real scorer.

Test Plan:
- Reset, then start → GEN lasts ≥4 cycles, then ENTRY. answer has four distinct nibbles, each ≤9; busy high only during GEN; guess=40'hFF_FFFF_FFFF.
- In ENTRY, send digits 3, 3, 12, 5, then backspace, then 7 → entry_count=2; guess[15:0]=16'hFF73.
- submit with 3 digits → ignored, stays in ENTRY, try_count=0. Enter the 4th digit, submit → result_valid 2 cycles after submit, try_count=1.
- Enter the answer nibbles in order and submit → last_strike=4, last_ball=0, win=1, try_count=1. Later digit/submit inputs are ignored.
- MAX_TRIES=2; enter 4 digits absent from answer twice → last_strike=0, last_ball=0 each time; lose=1 after the 2nd result; try_count=2.
- start mid-ENTRY with entry_count=3 → GEN, entry_count=0, try_count=0. Assert rst during SCORE → all outputs return to reset values immediately.
